sphere_column_gen: RTL

//  Sequential, parametrised sphere/ring column generator for the rotating HUB75 volumetric display.
//  On a start pulse it latches NUM_CH column indices plus shape settings (radius, colour, solid/shell mode, shell thickness).
//  It then sweeps every row, one row per cycle, and emits NUM_CH complete RGB columns with a done strobe.

---
 rtl/sphere_pkg.sv | 22 ++
 rtl/sphere_column_gen_dist_sq_pipe.sv | 48 ++++
 rtl/sphere_column_gen.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/sphere_pkg.sv
// Shared types and default geometry for the sphere column generator.
// Sweep FSM states, shape modes and derived datapath widths.
package sphere_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    DRAIN
  } sweep_state_t;

  typedef enum logic {
    SOLID,
    SHELL
  } shape_mode_t;

  localparam int DEF_ROWS = 64;
  localparam int DEF_COLS = 64;
  localparam int ROW_W    = $clog2(DEF_ROWS);
  localparam int COL_W    = $clog2(DEF_COLS);
  localparam int D2_W     = 2 * (ROW_W + 1) + 1;

endpackage

// File: rtl/sphere_column_gen_dist_sq_pipe.sv
// Two-stage |a-ac|^2 + |b-bc|^2 pipeline.
// Stage 1 registers the magnitudes, stage 2 the full-width sum of squares.
module dist_sq_pipe #(
  parameter int A_W = 6,
  parameter int B_W = 6,
  parameter int D_W = 7,
  parameter int A_C = 32,
  parameter int B_C = 32
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [A_W-1:0]   a_in,
  input  logic [B_W-1:0]   b_in,
  output logic [2*D_W:0]   d2_out
);

  localparam int P_W = 2 * D_W + 1;
  localparam logic signed [D_W:0] AC = (D_W + 1)'(A_C);
  localparam logic signed [D_W:0] BC = (D_W + 1)'(B_C);

  logic signed [D_W:0] da;
  logic signed [D_W:0] db;
  logic [D_W-1:0]      dx;
  logic [D_W-1:0]      dy;

  function automatic logic [D_W-1:0] mag(input logic signed [D_W:0] v);
    logic signed [D_W:0] n;
    n = -v;
    return v[D_W] ? n[D_W-1:0] : v[D_W-1:0];
  endfunction

  // Signed difference: edge columns give a plain magnitude, never a wrap.
  assign da = $signed((D_W + 1)'(a_in)) - AC;
  assign db = $signed((D_W + 1)'(b_in)) - BC;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      dx     <= '0;
      dy     <= '0;
      d2_out <= '0;
    end else begin
      dx     <= mag(da);
      dy     <= mag(db);
      d2_out <= P_W'(dx) * P_W'(dx) + P_W'(dy) * P_W'(dy);
    end
  end

endmodule

// File: rtl/sphere_column_gen.sv
// Sphere/ring column generator: sweeps all rows of NUM_CH columns
// through a distance pipeline and publishes whole columns at once.
module sphere_column_gen
  import sphere_pkg::*;
#(
  parameter int SCAN_RATE = 32,
  parameter int NUM_COLS  = 64,
  parameter int NUM_ROWS  = 64,
  parameter int RGB_RES   = 9,
  parameter int NUM_CH    = 2
) (
  input  logic                                clk_in,
  input  logic                                rst_in,
  input  logic                                start_in,
  input  logic [NUM_CH*$clog2(NUM_COLS)-1:0]  col_idx_in,
  input  logic [$clog2(NUM_ROWS)-1:0]         radius_in,
  input  logic [$clog2(NUM_ROWS)-1:0]         thick_in,
  input  logic                                mode_in,
  input  logic [RGB_RES-1:0]                  color_in,
  output logic                                busy_out,
  output logic                                valid_out,
  output logic [NUM_CH*NUM_ROWS*RGB_RES-1:0]  columns_out
);

  localparam int RW  = $clog2(NUM_ROWS);
  localparam int CW  = $clog2(NUM_COLS);
  localparam int DW  = RW + 1;
  localparam int D2W = 2 * DW + 1;
  localparam logic [1:0] DRAIN_LAST = 2'd2;

  sweep_state_t      state;
  shape_mode_t       mode_q;
  logic [RW-1:0]     y;
  logic [RW-1:0]     r_q;
  logic [RW-1:0]     t_q;
  logic [RGB_RES-1:0] color_q;
  logic [NUM_CH*CW-1:0] col_q;
  logic [1:0]        dcnt;
  logic              fin;

  logic              v1;
  logic              v2;
  logic [RW-1:0]     y1;
  logic [RW-1:0]     y2;

  logic [D2W-1:0]    d2 [NUM_CH];
  logic [D2W-1:0]    r2;
  logic [D2W-1:0]    ri2;
  logic [RW-1:0]     ri;
  logic              solid_like;
  logic [NUM_CH-1:0] lit;

  logic [RGB_RES-1:0] shadow [NUM_CH][NUM_ROWS];

  assign fin = (state == DRAIN) && (dcnt == DRAIN_LAST);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state     <= IDLE;
      busy_out  <= 1'b0;
      valid_out <= 1'b0;
      y         <= '0;
      dcnt      <= '0;
      r_q       <= '0;
      t_q       <= '0;
      mode_q    <= SOLID;
      color_q   <= '0;
      col_q     <= '0;
    end else begin
      valid_out <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_in) begin
            r_q      <= radius_in;
            t_q      <= thick_in;
            mode_q   <= shape_mode_t'(mode_in);
            color_q  <= color_in;
            col_q    <= col_idx_in;
            y        <= '0;
            busy_out <= 1'b1;
            state    <= SWEEP;
          end
        end
        SWEEP: begin
          y <= y + 1'b1;
          if (y == RW'(NUM_ROWS - 1)) begin
            dcnt  <= '0;
            state <= DRAIN;
          end
        end
        DRAIN: begin
          dcnt <= dcnt + 1'b1;
          if (fin) begin
            busy_out  <= 1'b0;
            valid_out <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Row tag and valid travel alongside the two distance stages.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      y1 <= '0;
      y2 <= '0;
    end else begin
      v1 <= (state == SWEEP);
      y1 <= y;
      v2 <= v1;
      y2 <= y1;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    dist_sq_pipe #(
      .A_W (CW),
      .B_W (RW),
      .D_W (DW),
      .A_C (SCAN_RATE),
      .B_C (NUM_ROWS / 2)
    ) u_pipe (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .a_in   (col_q[g*CW +: CW]),
      .b_in   (y),
      .d2_out (d2[g])
    );
  end

  assign ri  = (t_q >= r_q) ? '0 : r_q - t_q;
  assign r2  = D2W'(r_q) * D2W'(r_q);
  assign ri2 = D2W'(ri) * D2W'(ri);
  // A shell at least as thick as the radius degenerates to a disc.
  assign solid_like = (mode_q == SOLID) || (t_q >= r_q);

  always_comb begin
    lit = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      lit[c] = (d2[c] <= r2) && (solid_like || (d2[c] > ri2));
    end
  end

  always_ff @(posedge clk_in) begin
    if (v2) begin
      for (int c = 0; c < NUM_CH; c++) begin
        shadow[c][y2] <= lit[c] ? color_q : '0;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      columns_out <= '0;
    end else if (fin) begin
      for (int c = 0; c < NUM_CH; c++) begin
        for (int r = 0; r < NUM_ROWS; r++) begin
          columns_out[(c*NUM_ROWS + r)*RGB_RES +: RGB_RES] <= shadow[c][r];
        end
      end
    end
  end

endmodule
